// File: rtl/bpi_flash_pkt_prog.sv
// Programs one staged 128-word config packet from dual-port RAM into BPI flash, erasing the image region on packet 1.
// Optional read-back verify of every programmed word: define FLASH_VERIFY_EN.
//
// state      | meaning
// IDLE       | waiting for a staged packet
// CHK        | latch packet index/count, validate
// ERASE      | erase request for block blk, held until ack
// ERASE_WAIT | idle gap after an erase ack; next block or start programming
// RD         | RAM port B read of word w
// RD_LAT     | capture RAM read data
// PROG       | program request for word w, held until ack
// PROG_WAIT  | idle gap after a program ack; next word, verify or finish
// VER        | read-back request of word w, held until ack (verify build)
// VER_WAIT   | idle gap after a verify ack; next word or finish (verify build)
// CLR        | release staging RAM, report done
module bpi_flash_pkt_prog #(
   parameter int                ADDR_W           = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR        = '0,
   parameter int                ERASE_BLOCKS     = 8,
   parameter int                BLOCK_WORDS_LOG2 = 16
) (
   input  logic              clk_166m,
   input  logic              reset,
   input  logic              wr_flash_flag,
   input  logic              config_reset,
   input  logic [15:0]       pack_cnt,
   input  logic [15:0]       pack_num,
   output logic [6:0]        ram_addr,
   output logic              ram_en,
   input  logic [15:0]       ram_dout,
   output logic              flag_clr,
   output logic              fl_req,
   output logic [1:0]        fl_cmd,
   output logic [ADDR_W-1:0] fl_addr,
   output logic [15:0]       fl_wdata,
   input  logic              fl_ack,
   input  logic [15:0]       fl_rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BLK_W = (ERASE_BLOCKS < 2) ? 1 : $clog2(ERASE_BLOCKS + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHK,
      S_ERASE,
      S_ERASE_WAIT,
      S_RD,
      S_RD_LAT,
      S_PROG,
      S_PROG_WAIT,
`ifdef FLASH_VERIFY_EN
      S_VER,
      S_VER_WAIT,
`endif
      S_CLR
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [6:0]         w;
   logic [BLK_W-1:0]   blk;
   logic [15:0]        pc;
   logic [15:0]        pn;
   logic [15:0]        data_q;
   logic               err_pkt;
   logic               pkt_bad;
   logic               last_word;
   logic               erase_last;
   logic [ADDR_W-1:0]  erase_addr;
   logic [ADDR_W-1:0]  prog_addr;

   assign pkt_bad    = (pack_cnt == 16'd0) || (pack_cnt > pack_num);
   assign last_word  = (w == 7'd127);
   assign erase_last = (blk == BLK_W'(ERASE_BLOCKS));
   assign erase_addr = BASE_ADDR + (ADDR_W'(blk) << BLOCK_WORDS_LOG2);
   assign prog_addr  = BASE_ADDR + ((ADDR_W'(pc) - ADDR_W'(1)) << 7) + ADDR_W'(w);

`ifdef FLASH_VERIFY_EN
   state_t step_state;
   assign step_state = S_VER_WAIT;
`else
   state_t step_state;
   logic   unused_rdata;
   assign step_state   = S_PROG_WAIT;
   assign unused_rdata = ^fl_rdata;
`endif

   always_ff @(posedge clk_166m) begin
      if (reset) begin
         state   <= S_IDLE;
         w       <= '0;
         blk     <= '0;
         pc      <= '0;
         pn      <= '0;
         data_q  <= '0;
         err_pkt <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_CHK: begin
               pc      <= pack_cnt;
               pn      <= pack_num;
               w       <= '0;
               blk     <= '0;
               err_pkt <= pkt_bad;
               if (pkt_bad) err <= 1'b1;
            end
            S_ERASE: if (fl_ack) blk <= blk + BLK_W'(1);
            S_RD_LAT: data_q <= ram_dout;
`ifdef FLASH_VERIFY_EN
            S_VER: begin
               if (fl_ack && (fl_rdata != data_q)) begin
                  err_pkt <= 1'b1;
                  err     <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
         if ((state == step_state) && !last_word) w <= w + 7'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (wr_flash_flag) state_nxt = S_CHK;
         S_CHK:        state_nxt = pkt_bad ? S_CLR : (config_reset ? S_ERASE : S_RD);
         S_ERASE:      if (fl_ack) state_nxt = S_ERASE_WAIT;
         S_ERASE_WAIT: state_nxt = erase_last ? S_RD : S_ERASE;
         S_RD:         state_nxt = S_RD_LAT;
         S_RD_LAT:     state_nxt = S_PROG;
         S_PROG:       if (fl_ack) state_nxt = S_PROG_WAIT;
`ifdef FLASH_VERIFY_EN
         S_PROG_WAIT:  state_nxt = S_VER;
         S_VER:        if (fl_ack) state_nxt = S_VER_WAIT;
         S_VER_WAIT:   state_nxt = last_word ? S_CLR : S_RD;
`else
         S_PROG_WAIT:  state_nxt = last_word ? S_CLR : S_RD;
`endif
         S_CLR:        state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ram_addr = '0;
      ram_en   = 1'b0;
      flag_clr = 1'b0;
      fl_req   = 1'b0;
      fl_cmd   = 2'b00;
      fl_addr  = '0;
      fl_wdata = '0;
      done     = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_ERASE: begin
            fl_req  = 1'b1;
            fl_cmd  = 2'b01;
            fl_addr = erase_addr;
         end
         S_RD: begin
            ram_en   = 1'b1;
            ram_addr = w;
         end
         S_PROG: begin
            fl_req   = 1'b1;
            fl_cmd   = 2'b00;
            fl_addr  = prog_addr;
            fl_wdata = data_q;
         end
`ifdef FLASH_VERIFY_EN
         S_VER: begin
            fl_req   = 1'b1;
            fl_cmd   = 2'b10;
            fl_addr  = prog_addr;
            fl_wdata = data_q;
         end
`endif
         S_CLR: begin
            flag_clr = 1'b1;
            done     = (pc == pn) && !err_pkt;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bpi_flash_pkt_prog.sv
// Directed bench for bpi_flash_pkt_prog: RAM model, flash responder/logger, linear test sequence.
module tb_bpi_flash_pkt_prog;

`ifdef FLASH_VERIFY_EN
   localparam int STR = 2;
`else
   localparam int STR = 1;
`endif

   logic        clk_166m = 1'b0;
   logic        reset = 1'b1;
   logic        wr_flash_flag = 1'b0;
   logic        config_reset = 1'b0;
   logic [15:0] pack_cnt = '0;
   logic [15:0] pack_num = '0;
   logic [6:0]  ram_addr;
   logic        ram_en;
   logic [15:0] ram_dout = '0;
   logic        flag_clr;
   logic        fl_req;
   logic [1:0]  fl_cmd;
   logic [23:0] fl_addr;
   logic [15:0] fl_wdata;
   logic        fl_ack = 1'b0;
   logic [15:0] fl_rdata = '0;
   logic        busy;
   logic        done;
   logic        err;

   always #3 clk_166m = ~clk_166m;

   bpi_flash_pkt_prog dut (
      .clk_166m(clk_166m), .reset(reset), .wr_flash_flag(wr_flash_flag),
      .config_reset(config_reset), .pack_cnt(pack_cnt), .pack_num(pack_num),
      .ram_addr(ram_addr), .ram_en(ram_en), .ram_dout(ram_dout), .flag_clr(flag_clr),
      .fl_req(fl_req), .fl_cmd(fl_cmd), .fl_addr(fl_addr), .fl_wdata(fl_wdata),
      .fl_ack(fl_ack), .fl_rdata(fl_rdata), .busy(busy), .done(done), .err(err)
   );

   logic [15:0] ram_mem [0:127];

   always @(posedge clk_166m) if (ram_en) ram_dout <= ram_mem[ram_addr];

   // flash responder: acks a request once it has been held ack_delay cycles, logs accepted commands
   logic [1:0]  lc [0:2047];
   logic [23:0] la [0:2047];
   logic [15:0] ld [0:2047];
   int          lt [0:2047];
   int          log_n = 0;
   int          cyc = 0;
   int          req_age = 0;
   int          gap_viol = 0, stab_viol = 0, done_n = 0, rd_n = 0;
   int          ack_delay = 2;
   logic        stray_en = 1'b0, corrupt = 1'b0, prev_acc = 1'b0;
   logic [1:0]  p_cmd = '0;
   logic [23:0] p_addr = '0;
   logic [15:0] p_wdata = '0;

   always @(negedge clk_166m) begin
      cyc++;
      if (done) done_n++;
      if (prev_acc && fl_req) gap_viol++;
      if (fl_req && req_age > 0 && (fl_cmd !== p_cmd || fl_addr !== p_addr || fl_wdata !== p_wdata))
         stab_viol++;
      p_cmd   = fl_cmd;
      p_addr  = fl_addr;
      p_wdata = fl_wdata;
      prev_acc = 1'b0;
      if (fl_req) begin
         if (req_age >= ack_delay) begin
            fl_ack   = 1'b1;
            fl_rdata = ram_mem[fl_addr[6:0]] ^ ((corrupt && fl_addr[6:0] == 7'd10) ? 16'h0001 : 16'h0000);
            if (log_n < 2048) begin
               lc[log_n] = fl_cmd;
               la[log_n] = fl_addr;
               ld[log_n] = fl_wdata;
               lt[log_n] = cyc;
            end
            log_n++;
            if (fl_cmd == 2'b10) rd_n++;
            prev_acc = 1'b1;
            req_age  = 0;
         end else begin
            fl_ack = 1'b0;
            req_age++;
         end
      end else begin
         req_age = 0;
         fl_ack  = stray_en && cyc[0];
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_pkt(input logic [15:0] pc, input logic [15:0] pn, input logic era,
                          output int clr_cnt, output logic done_clr, output int cyc_to_clr);
      int post;
      post = -1;
      clr_cnt = 0;
      done_clr = 1'b0;
      cyc_to_clr = -1;
      @(negedge clk_166m);
      pack_cnt = pc;
      pack_num = pn;
      config_reset = era;
      wr_flash_flag = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk_166m);
         if (flag_clr === 1'b1) begin
            clr_cnt++;
            if (clr_cnt == 1) begin
               done_clr = done;
               cyc_to_clr = i + 1;
            end
            wr_flash_flag = 1'b0;
            if (post < 0) post = 0;
         end
         if (post >= 0) begin
            post++;
            if (post > 10) break;
         end
      end
      wr_flash_flag = 1'b0;
   endtask

   task automatic check_progs(input string tag, input int b, input int off, input logic [23:0] abase);
      int bad;
      bad = 0;
      for (int k = 0; k < 128; k++) begin
         int j;
         j = b + off + k * STR;
         if (j >= 2048) bad++;
         else if (lc[j] !== 2'b00 || la[j] !== abase + 24'(k) || ld[j] !== ram_mem[k]) bad++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic do_reset();
      @(negedge clk_166m);
      reset = 1'b1;
      repeat (2) @(negedge clk_166m);
      reset = 1'b0;
   endtask

   int   b, d0, clr, ct, bad, mdt;
   logic dc, found;

   initial begin
      for (int i = 0; i < 128; i++) ram_mem[i] = 16'(i);
      repeat (3) @(negedge clk_166m);
      chk("rst_ctrl", {fl_req, busy, flag_clr, done, err, ram_en}, 0);
      chk("rst_data", {ram_addr, fl_cmd, fl_wdata}, 0);
      chk("rst_addr", fl_addr, 0);
      reset = 1'b0;

      // packet 2 of 5, no erase, ack after 2 cycles
      b = log_n; d0 = done_n;
      run_pkt(16'd2, 16'd5, 1'b0, clr, dc, ct);
      chk("p2_clr_cnt", clr, 1);
      chk("p2_done_at_clr", dc, 0);
      chk("p2_done_cnt", done_n - d0, 0);
      chk("p2_err", err, 0);
      chk("p2_cmd_cnt", log_n - b, 128 * STR);
      chk("p2_first_addr", la[b], 24'h80);
      chk("p2_last_addr", la[b + 127 * STR], 24'hFF);
      check_progs("p2_progs", b, 0, 24'h80);

      // packet 1 of 1 with erase
      for (int i = 0; i < 128; i++) ram_mem[i] = 16'hA500 ^ 16'(i * 3);
      b = log_n; d0 = done_n;
      run_pkt(16'd1, 16'd1, 1'b1, clr, dc, ct);
      chk("p1_clr_cnt", clr, 1);
      chk("p1_done_at_clr", dc, 1);
      chk("p1_done_cnt", done_n - d0, 1);
      chk("p1_cmd_cnt", log_n - b, 8 + 128 * STR);
      bad = 0;
      for (int k = 0; k < 8; k++)
         if (lc[b + k] !== 2'b01 || la[b + k] !== (24'(k) << 16)) bad++;
      chk("p1_erase", bad, 0);
      chk("p1_erase7_addr", la[b + 7], 24'h070000);
      check_progs("p1_progs", b, 8, 24'h00);

      // invalid packet indices
      b = log_n; d0 = done_n;
      run_pkt(16'd0, 16'd5, 1'b0, clr, dc, ct);
      chk("pc0_cmd_cnt", log_n - b, 0);
      chk("pc0_err", err, 1);
      chk("pc0_clr_cnt", clr, 1);
      chk("pc0_done", done_n - d0, 0);
      do_reset();
      chk("err_cleared", err, 0);
      b = log_n; d0 = done_n;
      run_pkt(16'd6, 16'd5, 1'b1, clr, dc, ct);
      chk("pc6_cmd_cnt", log_n - b, 0);
      chk("pc6_err", err, 1);
      chk("pc6_clr_cnt", clr, 1);
      chk("pc6_done", done_n - d0, 0);
      do_reset();

      // immediate ack plus stray acks
      for (int i = 0; i < 128; i++) ram_mem[i] = 16'(i) ^ 16'h5A5A;
      ack_delay = 0; stray_en = 1'b1;
      b = log_n; d0 = done_n;
      run_pkt(16'd3, 16'd3, 1'b0, clr, dc, ct);
      stray_en = 1'b0; ack_delay = 2;
      chk("fast_cmd_cnt", log_n - b, 128 * STR);
      check_progs("fast_progs", b, 0, 24'h100);
      chk("fast_done_at_clr", dc, 1);
      chk("fast_err", err, 0);
      mdt = 1000000;
      for (int k = 0; k < 127; k++) begin
         int j;
         j = b + k * STR;
         if (lt[j + STR] - lt[j] < mdt) mdt = lt[j + STR] - lt[j];
      end
      chk("fast_min_word_cycles", (mdt >= 4), 1);
      chk("fast_pkt_cycles", (ct >= 514), 1);

      // reset while word 40 is being programmed
      for (int i = 0; i < 128; i++) ram_mem[i] = 16'hC000 + 16'(i);
      @(negedge clk_166m);
      pack_cnt = 16'd2; pack_num = 16'd5; config_reset = 1'b0; wr_flash_flag = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_166m);
         if (fl_req && fl_cmd == 2'b00 && fl_addr == 24'hA8) begin
            found = 1'b1;
            break;
         end
      end
      chk("mid_word40_seen", found, 1);
      reset = 1'b1;
      @(posedge clk_166m);
      #1;
      chk("mid_rst_ctrl", {fl_req, busy, flag_clr, done, err, ram_en}, 0);
      chk("mid_rst_data", {ram_addr, fl_cmd, fl_wdata}, 0);
      chk("mid_rst_addr", fl_addr, 0);
      wr_flash_flag = 1'b0;
      @(negedge clk_166m);
      reset = 1'b0;
      b = log_n;
      run_pkt(16'd2, 16'd5, 1'b0, clr, dc, ct);
      chk("restart_cmd_cnt", log_n - b, 128 * STR);
      chk("restart_first_addr", la[b], 24'h80);
      check_progs("restart_progs", b, 0, 24'h80);

`ifdef FLASH_VERIFY_EN
      // read-back mismatch on word 10 of the last packet
      corrupt = 1'b1;
      b = log_n; d0 = done_n; d0 = done_n;
      run_pkt(16'd4, 16'd4, 1'b0, clr, dc, ct);
      corrupt = 1'b0;
      chk("ver_cmd_cnt", log_n - b, 256);
      bad = 0;
      for (int k = 0; k < 128; k++)
         if (lc[b + 2 * k + 1] !== 2'b10 || la[b + 2 * k + 1] !== 24'h180 + 24'(k)) bad++;
      chk("ver_reads", bad, 0);
      check_progs("ver_progs", b, 0, 24'h180);
      chk("ver_err", err, 1);
      chk("ver_done_at_clr", dc, 0);
      chk("ver_done_cnt", done_n - d0, 0);
      chk("ver_clr_cnt", clr, 1);
`else
      chk("no_read_cmds", rd_n, 0);
`endif

      chk("req_gap_after_ack", gap_viol, 0);
      chk("req_stable", stab_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
